// File: rtl/lift_pkg.sv
// Shared direction encodings, FSM state type and default floor width
// for the lift scheduler and its SCAN target picker.
package lift_pkg;
  localparam int FLOOR_W_DEF = 3;

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  typedef enum logic [1:0] {IDLE, DISPATCH, MOVING, DOOR} state_t;
endpackage

// File: rtl/lift_target_pick.sv
// Combinational SCAN search: nearest pending floor strictly beyond cur_floor in the
// travel direction (idle prefers up), otherwise nearest one in the opposite direction.
module lift_target_pick
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS = 8,
  parameter int FLOOR_W    = FLOOR_W_DEF
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    cur_floor,
  input  logic [1:0]            dir,
  output logic                  found,
  output logic [FLOOR_W-1:0]    target,
  output logic [1:0]            new_dir
);
  logic [NUM_FLOORS-1:0] above;
  logic [NUM_FLOORS-1:0] below;
  logic [FLOOR_W-1:0]    up_tgt;
  logic [FLOOR_W-1:0]    dn_tgt;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FLOORS; gi++) begin : g_mask
      assign above[gi] = pending[gi] && (FLOOR_W'(gi) > cur_floor);
      assign below[gi] = pending[gi] && (FLOOR_W'(gi) < cur_floor);
    end
  endgenerate

  // Lowest set bit above, highest set bit below: the last assignment in each loop wins.
  always_comb begin
    up_tgt = '0;
    dn_tgt = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (above[i]) up_tgt = FLOOR_W'(i);
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (below[i]) dn_tgt = FLOOR_W'(i);
    end
  end

  always_comb begin
    found   = |(above | below);
    target  = cur_floor;
    new_dir = DIR_IDLE;
    if (dir == DIR_DOWN) begin
      if (|below) begin
        target  = dn_tgt;
        new_dir = DIR_DOWN;
      end else if (|above) begin
        target  = up_tgt;
        new_dir = DIR_UP;
      end
    end else begin
      if (|above) begin
        target  = up_tgt;
        new_dir = DIR_UP;
      end else if (|below) begin
        target  = dn_tgt;
        new_dir = DIR_DOWN;
      end
    end
  end
endmodule

// File: rtl/lift_scheduler.sv
// SCAN lift scheduler: pending-request bitmap, valid/ready target offer, door hold timer.
// Define LIFT_SCHED_STATS_EN to build the saturating serviced-stop counter on svc_count.
module lift_scheduler
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS  = 8,
  parameter int FLOOR_W     = FLOOR_W_DEF,
  parameter int DOOR_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  output logic                  tgt_valid,
  output logic [FLOOR_W-1:0]    tgt_floor,
  input  logic                  tgt_ready,
  input  logic                  arrive,
  input  logic [FLOOR_W-1:0]    arrive_floor,
  output logic [1:0]            dir,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending,
  output logic [15:0]           svc_count
);
  localparam int TIMER_W = $clog2(DOOR_CYCLES + 1);
  localparam logic [TIMER_W-1:0] DOOR_LOAD = TIMER_W'(DOOR_CYCLES - 1);

  state_t                state_reg, state_next;
  logic [NUM_FLOORS-1:0] pending_reg, pending_next;
  logic [FLOOR_W-1:0]    cur_floor_reg, cur_floor_next;
  logic [FLOOR_W-1:0]    tgt_floor_reg, tgt_floor_next;
  logic                  tgt_valid_reg, tgt_valid_next;
  logic [1:0]            dir_reg, dir_next;
  logic [TIMER_W-1:0]    timer_reg, timer_next;
  logic [NUM_FLOORS-1:0] req_hit, arrive_hit, cur_hit, set_mask, clr_mask;
  logic                  pick_found;
  logic [FLOOR_W-1:0]    pick_target;
  logic [1:0]            pick_dir;

  // One-hot decode; floors >= NUM_FLOORS decode to nothing and are dropped.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_FLOORS; gi++) begin : g_hit
      assign req_hit[gi]    = req_valid && (req_floor == FLOOR_W'(gi));
      assign arrive_hit[gi] = (arrive_floor == FLOOR_W'(gi));
      assign cur_hit[gi]    = (cur_floor_reg == FLOOR_W'(gi));
    end
  endgenerate

  lift_target_pick #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_pick (
    .pending   (pending_reg),
    .cur_floor (cur_floor_reg),
    .dir       (dir_reg),
    .found     (pick_found),
    .target    (pick_target),
    .new_dir   (pick_dir)
  );

  always_comb begin
    state_next     = state_reg;
    cur_floor_next = cur_floor_reg;
    tgt_floor_next = tgt_floor_reg;
    tgt_valid_next = tgt_valid_reg;
    dir_next       = dir_reg;
    timer_next     = timer_reg;
    set_mask       = req_hit;
    clr_mask       = '0;
    case (state_reg)
      IDLE: begin
        if (pending_reg == '0) begin
          dir_next = DIR_IDLE;
        end else if ((pending_reg & cur_hit) != '0) begin
          clr_mask   = cur_hit;
          timer_next = DOOR_LOAD;
          state_next = DOOR;
        end else begin
          state_next     = DISPATCH;
          tgt_valid_next = 1'b1;
          tgt_floor_next = pick_target;
          dir_next       = pick_dir;
        end
      end
      DISPATCH: begin
        if (tgt_ready) begin
          tgt_valid_next = 1'b0;
          state_next     = MOVING;
        end
      end
      MOVING: begin
        if (arrive) begin
          cur_floor_next = arrive_floor;
          clr_mask       = arrive_hit;
          timer_next     = DOOR_LOAD;
          state_next     = DOOR;
        end
      end
      DOOR: begin
        // A call for the floor we are standing at just keeps the door open.
        if (req_valid && (req_floor == cur_floor_reg)) begin
          set_mask   = '0;
          timer_next = DOOR_LOAD;
        end else if (timer_reg != '0) begin
          timer_next = timer_reg - TIMER_W'(1);
        end else if (pick_found) begin
          state_next     = DISPATCH;
          tgt_valid_next = 1'b1;
          tgt_floor_next = pick_target;
          dir_next       = pick_dir;
        end else begin
          state_next = IDLE;
          dir_next   = DIR_IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // Clear wins so a same-cycle request for the floor being served ends up served.
    pending_next = (pending_reg | set_mask) & ~clr_mask;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      pending_reg   <= '0;
      cur_floor_reg <= '0;
      tgt_floor_reg <= '0;
      tgt_valid_reg <= 1'b0;
      dir_reg       <= DIR_IDLE;
      timer_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      pending_reg   <= pending_next;
      cur_floor_reg <= cur_floor_next;
      tgt_floor_reg <= tgt_floor_next;
      tgt_valid_reg <= tgt_valid_next;
      dir_reg       <= dir_next;
      timer_reg     <= timer_next;
    end
  end

  assign tgt_valid = tgt_valid_reg;
  assign tgt_floor = tgt_floor_reg;
  assign dir       = dir_reg;
  assign door_open = (state_reg == DOOR);
  assign pending   = pending_reg;

`ifdef LIFT_SCHED_STATS_EN
  logic [15:0] svc_count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      svc_count_reg <= 16'h0000;
    end else if ((state_next == DOOR) && (state_reg != DOOR) && (svc_count_reg != 16'hFFFF)) begin
      svc_count_reg <= svc_count_reg + 16'd1;
    end
  end

  assign svc_count = svc_count_reg;
`else
  assign svc_count = 16'h0000;
`endif
endmodule
